// File: rtl/branch_pkg.sv
// Shared types and constants for the branch redirect front-end control.
package branch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FLUSH   = 2'd1,
      WAIT_IC = 2'd2
   } br_state_e;

   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [1:0] ALIGN_MASK  = 2'b11;
   localparam int         FLUSH_CNT_W = 4;

   // Targets must be word aligned; the two low bits are checked.
   function automatic logic is_aligned(input logic [1:0] lsb);
      return (lsb & ALIGN_MASK) == 2'b00;
   endfunction

   function automatic logic is_redirect_op(input logic [6:0] opcode);
      return (opcode == OP_BRANCH) || (opcode == OP_JAL);
   endfunction

endpackage

// File: rtl/redirect_stat_counter.sv
// Saturating up-counter with enable, used for redirect statistics.
module redirect_stat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: flush IF/ID, hold EX, hand new PC to the I-cache.
// Statistics counters are built only when BRANCH_REDIRECT_STATS_EN is defined.
module branch_redirect_ctrl
   import branch_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int STAT_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   input  logic              br_taken,
   input  logic [XLEN-1:0]   br_target,
   input  logic              ic_ready,
   output logic              redirect_valid,
   output logic [XLEN-1:0]   redirect_pc,
   output logic              flush_if,
   output logic              flush_id,
   output logic              stall_ex,
   output logic              misalign_exc,
   output logic              busy,
   output logic [STAT_W-1:0] taken_cnt,
   output logic [STAT_W-1:0] stall_cnt
);

   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD = FLUSH_CNT_W'(FLUSH_CYCLES - 1);

   br_state_e              state_reg;
   logic [FLUSH_CNT_W-1:0] flush_cnt_reg;
   logic                   hs_done_reg;
   logic                   accept;

   assign accept = redirect_valid & ic_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         flush_cnt_reg  <= '0;
         hs_done_reg    <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         flush_if       <= 1'b0;
         flush_id       <= 1'b0;
         stall_ex       <= 1'b0;
         misalign_exc   <= 1'b0;
         busy           <= 1'b0;
      end else begin
         misalign_exc <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (br_valid && br_taken) begin
                  if (is_aligned(br_target[1:0])) begin
                     state_reg      <= FLUSH;
                     redirect_pc    <= br_target;
                     flush_cnt_reg  <= FLUSH_LOAD;
                     hs_done_reg    <= 1'b0;
                     redirect_valid <= 1'b1;
                     flush_if       <= 1'b1;
                     flush_id       <= 1'b1;
                     stall_ex       <= 1'b1;
                     busy           <= 1'b1;
                  end else begin
                     misalign_exc <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               // Cache may take the PC early; remember it so the offer is not repeated.
               if (accept) begin
                  hs_done_reg    <= 1'b1;
                  redirect_valid <= 1'b0;
               end
               if (flush_cnt_reg == '0) begin
                  if (hs_done_reg || accept) begin
                     state_reg      <= IDLE;
                     redirect_valid <= 1'b0;
                     flush_if       <= 1'b0;
                     flush_id       <= 1'b0;
                     stall_ex       <= 1'b0;
                     busy           <= 1'b0;
                  end else begin
                     state_reg <= WAIT_IC;
                     flush_id  <= 1'b0;
                  end
               end else begin
                  flush_cnt_reg <= flush_cnt_reg - 1'b1;
               end
            end
            WAIT_IC: begin
               if (ic_ready) begin
                  state_reg      <= IDLE;
                  redirect_valid <= 1'b0;
                  flush_if       <= 1'b0;
                  stall_ex       <= 1'b0;
                  busy           <= 1'b0;
               end
            end
            default: begin
               state_reg      <= IDLE;
               redirect_valid <= 1'b0;
               flush_if       <= 1'b0;
               flush_id       <= 1'b0;
               stall_ex       <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

`ifdef BRANCH_REDIRECT_STATS_EN
   logic [1:0]        stat_en;
   logic [STAT_W-1:0] stat_val [2];

   assign stat_en[0] = accept;
   assign stat_en[1] = (state_reg == WAIT_IC);

   for (genvar gi = 0; gi < 2; gi++) begin : g_stat
      redirect_stat_counter #(.W(STAT_W)) u_cnt (
         .clk   (clk),
         .reset (reset),
         .en    (stat_en[gi]),
         .count (stat_val[gi])
      );
   end

   assign taken_cnt = stat_val[0];
   assign stall_cnt = stat_val[1];
`else
   assign taken_cnt = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Scoreboard bench for branch_redirect_ctrl: directed branches, expected events queued.
module tb_branch_redirect_ctrl;

   localparam int XLEN   = 32;
   localparam int STAT_W = 32;

`ifdef BRANCH_REDIRECT_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset;
   logic              br_valid;
   logic              br_taken;
   logic [XLEN-1:0]   br_target;
   logic              ic_ready;
   logic              redirect_valid;
   logic [XLEN-1:0]   redirect_pc;
   logic              flush_if;
   logic              flush_id;
   logic              stall_ex;
   logic              misalign_exc;
   logic              busy;
   logic [STAT_W-1:0] taken_cnt;
   logic [STAT_W-1:0] stall_cnt;

   logic [5:0] outs;
   assign outs = {redirect_valid, flush_if, flush_id, stall_ex, misalign_exc, busy};

   typedef struct {
      bit          mis;
      logic [31:0] pc;
   } ev_t;

   ev_t q[$];
   int  n_checks = 0;
   int  n_fail   = 0;
   int  exp_taken = 0;
   int  exp_stall = 0;

   always #5 clk = ~clk;

   branch_redirect_ctrl #(.XLEN(XLEN), .FLUSH_CYCLES(2), .STAT_W(STAT_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .br_valid       (br_valid),
      .br_taken       (br_taken),
      .br_target      (br_target),
      .ic_ready       (ic_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush_if       (flush_if),
      .flush_id       (flush_id),
      .stall_ex       (stall_ex),
      .misalign_exc   (misalign_exc),
      .busy           (busy),
      .taken_cnt      (taken_cnt),
      .stall_cnt      (stall_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Check the {rv, fi, fid, sx, mis, busy} vector in the current cycle.
   task automatic chk_outs(input string name, input logic [5:0] exp);
      @(negedge clk);
      chk(name, {58'd0, outs}, {58'd0, exp});
      $display("cycle check %s outs=%b", name, outs);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic taken, input logic [31:0] target);
      br_valid  = 1'b1;
      br_taken  = taken;
      br_target = target;
   endtask

   task automatic chk_stats(input string name);
      chk({name, " taken_cnt"}, {32'd0, taken_cnt}, STATS_ON ? 64'(exp_taken) : 64'd0);
      chk({name, " stall_cnt"}, {32'd0, stall_cnt}, STATS_ON ? 64'(exp_stall) : 64'd0);
   endtask

   // Monitor: every handshake or misalign pulse must match the next queued event.
   always @(negedge clk) begin
      if (!reset && ((redirect_valid && ic_ready) || misalign_exc)) begin
         if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected event: rv=%b mis=%b pc=%0h, required none", redirect_valid, misalign_exc, redirect_pc);
         end else begin
            ev_t ev;
            ev = q.pop_front();
            chk("event kind", {63'd0, misalign_exc}, {63'd0, ev.mis});
            if (!ev.mis) chk("handshake pc", {32'd0, redirect_pc}, {32'd0, ev.pc});
            $display("monitor event mis=%b pc=%0h", misalign_exc, redirect_pc);
         end
      end
      if (!reset && br_valid && busy) begin
         n_fail++;
         $display("FAIL upstream rule: br_valid=1 while busy=1, required no branch while busy");
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; br_valid = 1'b0; br_taken = 1'b0; br_target = '0; ic_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_outs("reset outs", 6'b000000);
      chk("reset pc", {32'd0, redirect_pc}, 64'd0);
      chk_stats("reset");
      adv();
      reset = 1'b0;

      // Test 1: quick handshake, ic_ready high.
      ic_ready = 1'b1;
      issue(1'b1, 32'h0000_0100);
      q.push_back('{mis: 1'b0, pc: 32'h0000_0100});
      chk_outs("t1 c0", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t1 c1", 6'b111101);
      chk("t1 pc", {32'd0, redirect_pc}, 64'h100);
      adv();
      chk_outs("t1 c2", 6'b011101);
      adv();
      chk_outs("t1 c3", 6'b000000);
      exp_taken++;
      chk_stats("t1");

      // Test 2: cache not ready until cycle 6.
      adv();
      ic_ready = 1'b0;
      issue(1'b1, 32'h0000_2000);
      q.push_back('{mis: 1'b0, pc: 32'h0000_2000});
      chk_outs("t2 c0", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t2 c1", 6'b111101);
      adv();
      chk_outs("t2 c2", 6'b111101);
      for (int c = 3; c <= 5; c++) begin
         adv();
         chk_outs($sformatf("t2 c%0d", c), 6'b110101);
         chk("t2 pc stable", {32'd0, redirect_pc}, 64'h2000);
      end
      adv();
      ic_ready = 1'b1;
      chk_outs("t2 c6", 6'b110101);
      adv();
      chk_outs("t2 c7", 6'b000000);
      exp_taken++;
      exp_stall += 4;
      chk_stats("t2");

      // Test 3: misaligned target.
      adv();
      issue(1'b1, 32'h0000_0102);
      q.push_back('{mis: 1'b1, pc: 32'h0});
      chk_outs("t3 c0", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t3 c1", 6'b000010);
      adv();
      chk_outs("t3 c2", 6'b000000);

      // Test 4: not-taken branches are ignored.
      adv();
      issue(1'b0, 32'h0000_0300);
      for (int c = 0; c < 10; c++) begin
         chk_outs($sformatf("t4 c%0d", c), 6'b000000);
         adv();
      end
      br_valid = 1'b0;
      chk_stats("t4");

      // Test 5: reset while waiting for the cache.
      ic_ready = 1'b0;
      issue(1'b1, 32'h0000_0500);
      chk_outs("t5 c0", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t5 c1", 6'b111101);
      adv();
      chk_outs("t5 c2", 6'b111101);
      adv();
      chk_outs("t5 c3", 6'b110101);
      adv();
      reset = 1'b1;
      chk_outs("t5 c4", 6'b110101);
      adv();
      reset = 1'b0;
      chk_outs("t5 c5", 6'b000000);
      exp_taken = 0;
      exp_stall = 0;
      chk_stats("t5 after reset");
      adv();
      adv();
      ic_ready = 1'b1;
      issue(1'b1, 32'h0000_0040);
      q.push_back('{mis: 1'b0, pc: 32'h0000_0040});
      chk_outs("t5 c7", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t5 c8", 6'b111101);
      chk("t5 pc", {32'd0, redirect_pc}, 64'h40);
      adv();
      chk_outs("t5 c9", 6'b011101);
      adv();
      chk_outs("t5 c10", 6'b000000);
      exp_taken++;

      // Test 6: second branch on the first IDLE cycle.
      adv();
      issue(1'b1, 32'h0000_0080);
      q.push_back('{mis: 1'b0, pc: 32'h0000_0080});
      chk_outs("t6 c0", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t6 c1", 6'b111101);
      adv();
      chk_outs("t6 c2", 6'b011101);
      adv();
      issue(1'b1, 32'h0000_00C0);
      q.push_back('{mis: 1'b0, pc: 32'h0000_00C0});
      chk_outs("t6 c3", 6'b000000);
      adv(); br_valid = 1'b0; br_taken = 1'b0;
      chk_outs("t6 c4", 6'b111101);
      chk("t6 pc2", {32'd0, redirect_pc}, 64'hC0);
      adv();
      chk_outs("t6 c5", 6'b011101);
      adv();
      chk_outs("t6 c6", 6'b000000);
      exp_taken += 2;
      chk_stats("t6");

      adv();
      adv();
      chk("scoreboard drained", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_redirect_ctrl.md
Name: branch_redirect_ctrl

Overview:
- Sequences the front-end response to a resolved taken branch or jump in each core of the multicore RISC-V pipeline.
- Consumes the registered `br_taken` pulse and target from the branch-condition stage.
- Squashes IF/ID for a fixed number of cycles and holds EX.
- Delivers the new PC to the instruction cache through a valid/ready handshake, retaining it until the cache accepts it, even across an outstanding miss.

Parameters:
- XLEN, 32, address width.
- FLUSH_CYCLES, 2, minimum cycles flush_if/flush_id stay asserted (legal range 1..15).
- STAT_W, 32, width of statistics counters (only used with the optional feature).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- br_valid  in  1  br_taken/br_target qualified this cycle
- br_taken  in  1  registered branch/jump outcome
- br_target  in  XLEN  computed target address
- ic_ready  in  1  I-cache accepts a new fetch address
- redirect_valid  out  1  redirect_pc is pending
- redirect_pc  out  XLEN  new fetch address
- flush_if  out  1  squash IF stage
- flush_id  out  1  squash ID stage
- stall_ex  out  1  hold EX; blocks further branch resolution
- misalign_exc  out  1  one-cycle pulse: taken target not 4-byte aligned
- busy  out  1  FSM not IDLE
- taken_cnt  out  STAT_W  taken redirects accepted
- stall_cnt  out  STAT_W  cycles spent in WAIT_IC

Behaviour:
- Reset state:
  - Synchronous; all outputs 0, FSM = IDLE, counters 0.
  - reset in any state aborts the pending redirect with no handshake completed.
- IDLE:
  - On br_valid & br_taken & br_target[1:0]==0: latch br_target into redirect_pc, load flush counter = FLUSH_CYCLES-1, go to FLUSH.
  - Outputs rise the next cycle, so latency is 1 cycle from resolution to redirect_valid.
  - On br_valid & br_taken & br_target[1:0]!=0: pulse misalign_exc the next cycle for 1 cycle, no redirect, stay IDLE.
  - br_valid & !br_taken: no action.
- FLUSH:
  - Asserts flush_if, flush_id, stall_ex, redirect_valid and busy.
  - Counter decrements each cycle.
  - Handshake = redirect_valid & ic_ready; it may complete in any FLUSH cycle. Record it in a done flag and drop redirect_valid from the next cycle.
  - When counter==0: if the handshake is done (including this cycle), go to IDLE; else go to WAIT_IC.
- WAIT_IC:
  - Asserts redirect_valid, flush_if, stall_ex and busy; flush_id = 0.
  - redirect_pc is stable.
  - On ic_ready, go to IDLE; all outputs drop the next cycle.
- Back-to-back branches:
  - br_valid while not IDLE is ignored; EX is stalled, so it is illegal upstream. The bench asserts it never occurs.
  - A new branch is accepted on the first IDLE cycle.
- redirect_pc holds its last value in IDLE and is only meaningful while redirect_valid is high.
- stall_cnt increments every cycle in WAIT_IC. taken_cnt increments on each accepted handshake. Both saturate at all-ones.

Optional Feature:
- BRANCH_REDIRECT_STATS_EN
  - Defined: taken_cnt and stall_cnt are implemented as described.
  - Undefined: both ports are driven constant 0, the counter logic is absent and the port list is unchanged.

Decomposition:
- Shared package branch_pkg:
  - FSM state enum (IDLE, FLUSH, WAIT_IC).
  - RISC-V opcode constants OP_BRANCH=7'b1100011 and OP_JAL=7'b1101111.
  - Alignment mask constant.
- One natural sub-module, redirect_stat_counter: saturating STAT_W counter with enable. It is instantiated twice under the macro.

Test Plan:
- FLUSH_CYCLES=2, ic_ready=1. br_valid=1, br_taken=1, br_target=0x0000_0100 at cycle 0 -> cycles 1-2: flush_if=flush_id=stall_ex=1; redirect_valid=1 only at cycle 1 (handshake); redirect_pc=0x100; busy=0 at cycle 3; taken_cnt=1.
- ic_ready=0 until cycle 6, target 0x0000_2000 -> FLUSH cycles 1-2, WAIT_IC cycles 3-6 with flush_id=0; handshake at cycle 6; IDLE at cycle 7; stall_cnt=4.
- br_taken=1, br_target=0x0000_0102 -> misalign_exc pulses exactly one cycle; redirect_valid, flush_if and busy all remain 0.
- br_valid=1, br_taken=0 for 10 cycles -> all outputs remain 0, counters unchanged.
- reset asserted in WAIT_IC with redirect pending -> next cycle all outputs 0 and FSM IDLE. A branch to 0x0000_0040 two cycles later is redirected normally.
- Two branches separated by exactly one cycle after return to IDLE (ic_ready=1) -> two handshakes, redirect_pc 0x80 then 0xC0, taken_cnt=2.
